// File: rtl/vram_arbiter.sv
// Framebuffer RAM arbiter: a buffered PPU write stream shares one single-port RAM
// with 256-pixel scanout line bursts. States: IDLE (writes only) | RD_BURST (reads + steals) | RD_DRAIN (await returns).
module vram_arbiter #(
  parameter int WFIFO_DEPTH = 8,
  parameter int RUN_MAX     = 8,
  parameter int RD_LAT      = 2
) (
  input  logic        clk_vga,
  input  logic        reset,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [15:0] wr_addr,
  input  logic [7:0]  wr_data,
  input  logic        rd_req,
  input  logic [7:0]  rd_line,
  output logic        rd_busy,
  output logic        rd_done,
  output logic        rd_overrun,
  output logic        lb_we,
  output logic [7:0]  lb_addr,
  output logic [7:0]  lb_data,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  localparam int AW = $clog2(WFIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = $clog2(RUN_MAX + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    RD_DRAIN = 2'd2
  } state_t;

  state_t        state_q;
  logic [7:0]    line_q;
  logic [7:0]    x_q;
  logic [RW-1:0] run_q;

  logic [23:0]   fifo_q [WFIFO_DEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [CW-1:0] count_q;
  logic [23:0]   head;
  logic          push;
  logic          pop;
  logic          urgent;

  logic [RD_LAT:0] pipe_v_q;
  logic [7:0]      pipe_x_q [RD_LAT+1];

  logic          do_wr;
  logic          do_rd;
  logic [7:0]    rd_x;
  logic [7:0]    rd_y;

  logic [15:0]   mem_addr_q;
  logic          mem_we_q;
  logic [7:0]    mem_wdata_q;
  logic          lb_we_q;
  logic [7:0]    lb_addr_q;
  logic [7:0]    lb_data_q;
  logic          rd_busy_q;
  logic          rd_done_q;
  logic          rd_overrun_q;

  assign wr_ready   = (count_q < CW'(WFIFO_DEPTH));
  assign push       = wr_valid && wr_ready;
  assign pop        = do_wr;
  assign head       = fifo_q[rptr_q];
  assign urgent     = (count_q >= CW'(WFIFO_DEPTH - 2));

  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;
  assign lb_we      = lb_we_q;
  assign lb_addr    = lb_addr_q;
  assign lb_data    = lb_data_q;
  assign rd_busy    = rd_busy_q;
  assign rd_done    = rd_done_q;
  assign rd_overrun = rd_overrun_q;

  // Slot choice for the next RAM cycle. An accepted rd_req with an empty FIFO
  // issues read x=0 straight away so the first address appears one cycle later.
  always_comb begin
    do_wr = 1'b0;
    do_rd = 1'b0;
    rd_x  = x_q;
    rd_y  = line_q;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          do_wr = 1'b1;
        end else if (rd_req) begin
          do_rd = 1'b1;
          rd_x  = 8'h00;
          rd_y  = rd_line;
        end
      end
      RD_BURST: begin
        if (urgent || ((run_q == RW'(RUN_MAX)) && (count_q != '0))) begin
          do_wr = 1'b1;
        end else begin
          do_rd = 1'b1;
        end
      end
      RD_DRAIN: do_wr = (count_q != '0);
      default: begin
        do_wr = 1'b0;
        do_rd = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_vga) begin
    if (push) begin
      fifo_q[wptr_q] <= {wr_addr, wr_data};
    end
  end

  always_ff @(posedge clk_vga or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Read-return tracker: one stage per cycle from address to registered data.
  always_ff @(posedge clk_vga or posedge reset) begin
    if (reset) begin
      pipe_v_q  <= '0;
      for (int i = 0; i <= RD_LAT; i++) pipe_x_q[i] <= 8'h00;
      lb_we_q   <= 1'b0;
      lb_addr_q <= 8'h00;
      lb_data_q <= 8'h00;
    end else begin
      pipe_v_q    <= {pipe_v_q[RD_LAT-1:0], do_rd};
      pipe_x_q[0] <= rd_x;
      for (int i = 1; i <= RD_LAT; i++) pipe_x_q[i] <= pipe_x_q[i-1];
      lb_we_q <= pipe_v_q[RD_LAT];
      if (pipe_v_q[RD_LAT]) begin
        lb_addr_q <= pipe_x_q[RD_LAT];
        lb_data_q <= mem_rdata;
      end
    end
  end

  always_ff @(posedge clk_vga or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      line_q       <= 8'h00;
      x_q          <= 8'h00;
      run_q        <= '0;
      mem_addr_q   <= 16'h0000;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= 8'h00;
      rd_busy_q    <= 1'b0;
      rd_done_q    <= 1'b0;
      rd_overrun_q <= 1'b0;
    end else begin
      rd_done_q    <= 1'b0;
      rd_overrun_q <= rd_req && rd_busy_q;

      if (do_wr) begin
        mem_we_q    <= 1'b1;
        mem_addr_q  <= head[23:8];
        mem_wdata_q <= head[7:0];
      end else if (do_rd) begin
        mem_we_q    <= 1'b0;
        mem_addr_q  <= {rd_y, rd_x};
      end else begin
        mem_we_q    <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (rd_req) begin
            line_q    <= rd_line;
            rd_busy_q <= 1'b1;
            state_q   <= RD_BURST;
            x_q       <= do_rd ? 8'h01 : 8'h00;
            run_q     <= do_rd ? RW'(1) : '0;
          end
        end
        RD_BURST: begin
          if (do_wr) begin
            run_q <= '0;
          end else begin
            x_q <= x_q + 8'h01;
            if (run_q != RW'(RUN_MAX)) run_q <= run_q + RW'(1);
            if (x_q == 8'hFF) state_q <= RD_DRAIN;
          end
        end
        RD_DRAIN: begin
          if (pipe_v_q == '0) begin
            state_q   <= IDLE;
            rd_busy_q <= 1'b0;
            rd_done_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: table of burst scenarios plus hand sequences for reset and
// idle writes; a negedge monitor scores RAM writes and line-buffer fills against queues.
module tb_vram_arbiter;

  logic        clk_vga = 1'b0;
  logic        reset   = 1'b1;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [15:0] wr_addr = 16'h0000;
  logic [7:0]  wr_data = 8'h00;
  logic        rd_req  = 1'b0;
  logic [7:0]  rd_line = 8'h00;
  logic        rd_busy, rd_done, rd_overrun;
  logic        lb_we;
  logic [7:0]  lb_addr, lb_data;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  always #5 clk_vga = ~clk_vga;

  vram_arbiter dut (
    .clk_vga(clk_vga), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_line(rd_line), .rd_busy(rd_busy), .rd_done(rd_done),
    .rd_overrun(rd_overrun), .lb_we(lb_we), .lb_addr(lb_addr), .lb_data(lb_data),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // RAM read content is a fixed function of the address; data valid two cycles after address.
  function automatic logic [7:0] pix(input logic [15:0] a);
    return (a[15:8] * 8'd3) ^ a[7:0] ^ 8'h5A;
  endfunction

  logic [15:0] ram_a1 = 16'h0000;
  logic [7:0]  ram_q  = 8'h00;
  always @(posedge clk_vga) begin
    ram_a1 <= mem_addr;
    ram_q  <= pix(ram_a1);
  end
  assign mem_rdata = ram_q;

  int cyc = 0;
  always @(posedge clk_vga) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  logic [23:0] wr_q[$];
  logic [15:0] lb_q[$];
  logic [7:0]  burst_line   = 8'h00;
  bit          burst_reading = 1'b0;
  int steals   = 0;
  int first_we = -1;
  int first_lb = -1;
  int done_cyc = -1;
  int ovr_cyc  = -1;
  int done_cnt = 0;
  int we_cnt   = 0;

  always @(negedge clk_vga) begin
    logic [23:0] ew;
    logic [15:0] el;
    if (!reset) begin
      if (wr_valid && wr_ready) wr_q.push_back({wr_addr, wr_data});
      if (mem_we) begin
        we_cnt++;
        if (burst_reading) begin
          steals++;
          if (first_we < 0) first_we = cyc;
        end
        if (wr_q.size() == 0) check("wr_unexpected", 64'd1, 64'd0);
        else begin
          ew = wr_q.pop_front();
          check("wr_addr_data", {40'd0, mem_addr, mem_wdata}, {40'd0, ew});
        end
      end else if (burst_reading && mem_addr == {burst_line, 8'hFF}) begin
        burst_reading = 1'b0;
      end
      if (lb_we) begin
        if (first_lb < 0) first_lb = cyc;
        if (lb_q.size() == 0) check("lb_unexpected", 64'd1, 64'd0);
        else begin
          el = lb_q.pop_front();
          check("lb_addr_data", {48'd0, lb_addr, lb_data}, {48'd0, el});
        end
      end
      if (rd_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (rd_overrun) ovr_cyc = cyc;
    end
  end

  typedef struct {
    logic [7:0] line;
    int mode;          // 0 no writes, 1 one queued write, 2 continuous writes
    int ovr_at;        // relative cycle of an extra rd_req, -1 none
    int exp_steals;    // -1: measured, must be nonzero
    int exp_first_we;  // relative cycle of first stolen write, -1 unchecked
    int exp_first_lb;
  } burst_vec_t;

  task automatic wait_idle();
    for (int k = 0; k < 400 && rd_busy; k++) begin
      @(posedge clk_vga); #1;
    end
    check("idle_reached", {63'd0, rd_busy}, 64'd0);
  endtask

  task automatic start_burst(input logic [7:0] line, output int start);
    for (int x = 0; x < 256; x++) lb_q.push_back({8'(x), pix({line, 8'(x)})});
    burst_line    = line;
    burst_reading = 1'b1;
    steals   = 0;
    first_we = -1;
    first_lb = -1;
    done_cyc = -1;
    ovr_cyc  = -1;
    rd_req   = 1'b1;
    rd_line  = line;
    start    = cyc;
  endtask

  task automatic run_burst(input burst_vec_t v);
    int start, rel, sexp;
    wait_idle();
    start_burst(v.line, start);
    rel = 0;
    while (done_cyc < 0 && rel < 700) begin
      @(posedge clk_vga); #1;
      rel      = cyc - start;
      rd_req   = (rel == v.ovr_at);
      rd_line  = (rel == v.ovr_at) ? ~v.line : v.line;
      wr_valid = (v.mode == 1 && rel == 2) || (v.mode == 2 && rel >= 1 && rel < 200);
      wr_addr  = {(v.mode == 1) ? 8'hC1 : 8'hA0, 8'(rel)};
      wr_data  = 8'(rel) ^ 8'h33;
      if (rel == 1) check("busy_rise", {63'd0, rd_busy}, 64'd1);
      if (v.mode == 0 && rel == 1)
        check("first_read_addr", {47'd0, mem_we, mem_addr}, {47'd0, 1'b0, v.line, 8'h00});
      if (v.mode == 0 && rel == 256)
        check("last_read_addr", {47'd0, mem_we, mem_addr}, {47'd0, 1'b0, v.line, 8'hFF});
    end
    wr_valid = 1'b0;
    rd_req   = 1'b0;
    if (done_cyc < 0) begin
      check("done_timeout", 64'd0, 64'd1);
    end else begin
      sexp = (v.exp_steals >= 0) ? v.exp_steals : steals;
      check("done_time", 64'(done_cyc - start), 64'(260 + sexp));
      if (v.exp_steals >= 0) check("steals", 64'(steals), 64'(v.exp_steals));
      else check("steals_nonzero", {63'd0, steals > 0}, 64'd1);
      check("first_lb_time", 64'(first_lb - start), 64'(v.exp_first_lb));
      if (v.exp_first_we >= 0) check("first_steal_time", 64'(first_we - start), 64'(v.exp_first_we));
      if (v.ovr_at >= 0) check("overrun_time", 64'(ovr_cyc - start), 64'(v.ovr_at + 1));
      else check("no_overrun", 64'(ovr_cyc), 64'(-1));
      check("busy_fall", {63'd0, rd_busy}, 64'd0);
    end
    check("lb_all_seen", 64'(lb_q.size()), 64'd0);
    repeat (20) @(posedge clk_vga);
    #1;
    check("writes_drained", 64'(wr_q.size()), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    burst_vec_t vecs[4];
    burst_vec_t after_rst;
    int start, we0, dc0;
    vecs[0] = '{8'h3C, 0, -1,  0, -1, 4};
    vecs[1] = '{8'h71, 1, -1,  1,  9, 4};
    vecs[2] = '{8'h92, 0, 50,  0, -1, 4};
    vecs[3] = '{8'hB4, 2, -1, -1, -1, 4};
    after_rst = '{8'h66, 0, -1, 0, -1, 4};

    @(posedge clk_vga); #1;
    check("reset_outputs", {19'd0, mem_addr, mem_we, mem_wdata, lb_we, lb_addr, lb_data,
                            rd_busy, rd_done, rd_overrun}, 64'd0);
    check("reset_wr_ready", {63'd0, wr_ready}, 64'd1);
    @(posedge clk_vga); #1;
    reset = 1'b0;
    @(posedge clk_vga); #1;

    // Back-to-back idle writes: the pop rate matches the push rate.
    we0 = we_cnt;
    for (int i = 0; i < 8; i++) begin
      wr_valid = 1'b1;
      wr_addr  = 16'h1234 + 16'(i);
      wr_data  = 8'(i);
      check("wr_ready_idle", {63'd0, wr_ready}, 64'd1);
      @(posedge clk_vga); #1;
    end
    wr_valid = 1'b0;
    repeat (6) @(posedge clk_vga);
    #1;
    check("idle_write_count", 64'(we_cnt - we0), 64'd8);
    check("idle_writes_drained", 64'(wr_q.size()), 64'd0);

    for (int i = 0; i < 4; i++) run_burst(vecs[i]);

    // Abort a burst mid-line with an asynchronous reset.
    wait_idle();
    dc0 = done_cnt;
    start_burst(8'h55, start);
    for (int k = 0; k < 300 && mem_addr != 16'h5564; k++) begin
      @(posedge clk_vga); #1;
      rd_req = 1'b0;
    end
    check("reached_x100", {48'd0, mem_addr}, 64'h5564);
    #2 reset = 1'b1;
    #1;
    check("midburst_reset_outputs", {19'd0, mem_addr, mem_we, mem_wdata, lb_we, lb_addr, lb_data,
                                     rd_busy, rd_done, rd_overrun}, 64'd0);
    check("midburst_reset_wr_ready", {63'd0, wr_ready}, 64'd1);
    lb_q.delete();
    burst_reading = 1'b0;
    @(posedge clk_vga); #1;
    reset = 1'b0;
    repeat (8) @(posedge clk_vga);
    #1;
    check("no_done_after_abort", 64'(done_cnt - dc0), 64'd0);
    run_burst(after_rst);

    check("total_done_pulses", 64'(done_cnt), 64'd5);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
